// File: rtl/axi_bm_pkg.sv
// Shared types and helpers for the AXI burst master: FSM states, status bit positions,
// and the 32-bit test pattern word.
package axi_bm_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAw,
    StW,
    StB,
    StAr,
    StR,
    StDone
  } state_t;

  localparam int unsigned StatCfgErr  = 0;
  localparam int unsigned StatLenErr  = 1;
  localparam int unsigned StatTimeout = 2;

  // One 32-bit lane of pattern(k); the data bus carries DATA_W/32 copies of it.
  function automatic logic [31:0] pattern_word(input logic [31:0] seed, input logic [7:0] k);
    return seed + {24'd0, k};
  endfunction

endpackage

// File: rtl/axi_bm_watchdog.sv
// Handshake watchdog: counts cycles since the last clear and flags expiry at TIMEOUT.
module axi_bm_watchdog #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic ACLK,
  input  logic ARESETn,
  input  logic clear,
  output logic expire
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q;

  assign expire = (cnt_q == CntW'(TIMEOUT));

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (!expire) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/axi_burst_master.sv
// Simulation AXI master: one INCR write burst, wait for B, read the same range back and
// compare every beat against the written pattern.
module axi_burst_master
  import axi_bm_pkg::*;
#(
  parameter int unsigned DATA_W  = 1024,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [7:0]        cfg_len,
  input  logic [31:0]       cfg_seed,
  output logic [ADDR_W-1:0] AWADDR,
  output logic [7:0]        AWLEN,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic              WLAST,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic              BVALID,
  output logic              BREADY,
  output logic [ADDR_W-1:0] ARADDR,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [DATA_W-1:0] RDATA,
  input  logic              RLAST,
  input  logic              RVALID,
  output logic              RREADY,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        err_cnt,
  output logic [2:0]        status
);

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic [31:0]       seed_q;
  logic [7:0]        k_q;

  logic              wd_clear;
  logic              wd_expire;
  logic [ADDR_W:0]   cfg_end;
  logic              cfg_bad;

  function automatic logic [DATA_W-1:0] beat_data(input logic [31:0] seed, input logic [7:0] k);
    return {(DATA_W / 32){pattern_word(seed, k)}};
  endfunction

  assign cfg_end = {1'b0, cfg_addr} + {{(ADDR_W - 7){1'b0}}, cfg_len};
  assign cfg_bad = (cfg_end >= (ADDR_W + 1)'(DEPTH));

  // Any handshake or beat restarts the watchdog; outside bus states it is held cleared.
  always_comb begin
    wd_clear = 1'b1;
    unique case (state_q)
      StAw:    wd_clear = AWVALID && AWREADY;
      StW:     wd_clear = WVALID && WREADY;
      StB:     wd_clear = BVALID && BREADY;
      StAr:    wd_clear = ARVALID && ARREADY;
      StR:     wd_clear = RVALID && RREADY;
      default: wd_clear = 1'b1;
    endcase
  end

  axi_bm_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .ACLK   (ACLK),
    .ARESETn(ARESETn),
    .clear  (wd_clear),
    .expire (wd_expire)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= StIdle;
      addr_q  <= '0;
      len_q   <= '0;
      seed_q  <= '0;
      k_q     <= '0;
      AWADDR  <= '0;
      AWLEN   <= '0;
      AWVALID <= 1'b0;
      WDATA   <= '0;
      WLAST   <= 1'b0;
      WVALID  <= 1'b0;
      BREADY  <= 1'b0;
      ARADDR  <= '0;
      ARVALID <= 1'b0;
      RREADY  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      err_cnt <= '0;
      status  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          busy <= 1'b0;
          if (start) begin
            busy    <= 1'b1;
            pass    <= 1'b0;
            err_cnt <= '0;
            status  <= '0;
            if (cfg_bad) begin
              status[StatCfgErr] <= 1'b1;
              state_q            <= StDone;
            end else begin
              addr_q  <= cfg_addr;
              len_q   <= cfg_len;
              seed_q  <= cfg_seed;
              AWADDR  <= cfg_addr;
              AWLEN   <= cfg_len;
              AWVALID <= 1'b1;
              state_q <= StAw;
            end
          end
        end
        StAw: begin
          if (AWVALID && AWREADY) begin
            AWVALID <= 1'b0;
            WVALID  <= 1'b1;
            WDATA   <= beat_data(seed_q, 8'd0);
            WLAST   <= (len_q == 8'd0);
            k_q     <= 8'd0;
            state_q <= StW;
          end else if (wd_expire) begin
            AWVALID              <= 1'b0;
            status[StatTimeout]  <= 1'b1;
            state_q              <= StDone;
          end
        end
        StW: begin
          if (WVALID && WREADY) begin
            if (k_q == len_q) begin
              WVALID  <= 1'b0;
              WLAST   <= 1'b0;
              BREADY  <= 1'b1;
              state_q <= StB;
            end else begin
              k_q   <= k_q + 8'd1;
              WDATA <= beat_data(seed_q, k_q + 8'd1);
              WLAST <= ((k_q + 8'd1) == len_q);
            end
          end else if (wd_expire) begin
            WVALID              <= 1'b0;
            WLAST               <= 1'b0;
            status[StatTimeout] <= 1'b1;
            state_q             <= StDone;
          end
        end
        StB: begin
          if (BVALID && BREADY) begin
            BREADY  <= 1'b0;
            ARADDR  <= addr_q;
            ARVALID <= 1'b1;
            state_q <= StAr;
          end else if (wd_expire) begin
            BREADY              <= 1'b0;
            status[StatTimeout] <= 1'b1;
            state_q             <= StDone;
          end
        end
        StAr: begin
          if (ARVALID && ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            k_q     <= 8'd0;
            state_q <= StR;
          end else if (wd_expire) begin
            ARVALID             <= 1'b0;
            status[StatTimeout] <= 1'b1;
            state_q             <= StDone;
          end
        end
        StR: begin
          if (RVALID && RREADY) begin
            if (RDATA != beat_data(seed_q, k_q) && err_cnt != 8'hFF) begin
              err_cnt <= err_cnt + 8'd1;
            end
            // Length error: RLAST too early, or the final beat arrives without RLAST.
            if (RLAST != (k_q == len_q)) begin
              status[StatLenErr] <= 1'b1;
            end
            k_q <= k_q + 8'd1;
            if (RLAST) begin
              RREADY  <= 1'b0;
              state_q <= StDone;
            end
          end else if (wd_expire) begin
            RREADY              <= 1'b0;
            status[StatTimeout] <= 1'b1;
            state_q             <= StDone;
          end
        end
        StDone: begin
          done    <= 1'b1;
          pass    <= (status == 3'b000) && (err_cnt == 8'd0);
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// Bench for axi_burst_master: behavioural AXI slave with fault knobs plus per-scenario checks.
module tb_axi_burst_master;

  localparam int unsigned DATA_W  = 128;
  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned DEPTH   = 64;
  localparam int unsigned TIMEOUT = 256;
  localparam int unsigned NW      = DATA_W / 32;

  logic              ACLK = 1'b0;
  logic              ARESETn = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] cfg_addr = '0;
  logic [7:0]        cfg_len = '0;
  logic [31:0]       cfg_seed = '0;
  logic [ADDR_W-1:0] AWADDR, ARADDR;
  logic [7:0]        AWLEN;
  logic              AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic              ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [DATA_W-1:0] WDATA, RDATA;
  logic              busy, done, pass;
  logic [7:0]        err_cnt;
  logic [2:0]        status;

  int checks = 0;
  int errors = 0;

  always #5 ACLK = ~ACLK;

  axi_burst_master #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .start   (start),
    .cfg_addr(cfg_addr),
    .cfg_len (cfg_len),
    .cfg_seed(cfg_seed),
    .AWADDR  (AWADDR),
    .AWLEN   (AWLEN),
    .AWVALID (AWVALID),
    .AWREADY (AWREADY),
    .WDATA   (WDATA),
    .WLAST   (WLAST),
    .WVALID  (WVALID),
    .WREADY  (WREADY),
    .BVALID  (BVALID),
    .BREADY  (BREADY),
    .ARADDR  (ARADDR),
    .ARVALID (ARVALID),
    .ARREADY (ARREADY),
    .RDATA   (RDATA),
    .RLAST   (RLAST),
    .RVALID  (RVALID),
    .RREADY  (RREADY),
    .busy    (busy),
    .done    (done),
    .pass    (pass),
    .err_cnt (err_cnt),
    .status  (status)
  );

  // Slave knobs and observations
  bit  rand_ready = 1'b1;
  bit  b_never = 1'b0;
  int  w_stall_beat = -1;
  int  corrupt_beat = -1;
  int  early_last = -1;
  int  aw_seen, ar_seen, w_beats, r_beats, hold_viol, ncyc, b_first;
  logic [DATA_W-1:0] wcap[$];
  bit  wlast_cap[$];

  logic [DATA_W-1:0] mem[DEPTH];
  int  s_addr, s_len, wk, rj, stall_left;
  bit  b_pend, r_act, stalled;
  logic p_awv, p_awr, p_wv, p_wr, p_wl, p_bv, p_br, p_arv, p_arr, p_rv, p_rr, p_rl;
  logic [DATA_W-1:0] p_wdata;
  logic [ADDR_W-1:0] p_awaddr;
  logic [7:0]        p_awlen;

  // Slave acts on negedges; the snapshot taken here is what the next posedge sees.
  always @(negedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0; RLAST = 0; RDATA = '0;
      b_pend = 0; r_act = 0; wk = 0; rj = 0; stall_left = 0; stalled = 0;
      {p_awv, p_awr, p_wv, p_wr, p_wl, p_bv, p_br, p_arv, p_arr, p_rv, p_rr, p_rl} = '0;
      p_wdata = '0; p_awaddr = '0; p_awlen = '0;
    end else begin
      ncyc++;
      if (p_wv && !p_wr && (!WVALID || WDATA !== p_wdata || WLAST !== p_wl)) hold_viol++;
      if (p_awv && !p_awr && (!AWVALID || AWADDR !== p_awaddr)) hold_viol++;
      if (p_arv && !p_arr && !ARVALID) hold_viol++;
      if (AWVALID) aw_seen++;
      if (ARVALID) ar_seen++;
      if (BREADY && b_first < 0) b_first = ncyc;
      if (p_awv && p_awr) begin
        s_addr = int'(p_awaddr[31:0]); s_len = int'(p_awlen); wk = 0; stalled = 0;
      end
      if (p_wv && p_wr) begin
        wcap.push_back(p_wdata); wlast_cap.push_back(p_wl);
        mem[(s_addr + wk) % DEPTH] = p_wdata;
        w_beats++; wk++;
        if (p_wl) b_pend = 1;
      end
      if (p_bv && p_br) b_pend = 0;
      if (p_arv && p_arr) begin r_act = 1; rj = 0; end
      if (p_rv && p_rr) begin
        r_beats++; rj++;
        if (p_rl) r_act = 0;
      end
      AWREADY = AWVALID && (!rand_ready || $urandom_range(0, 1) == 1);
      if (stall_left > 0) begin
        WREADY = 0; stall_left--;
      end else if (WVALID && wk == w_stall_beat && !stalled) begin
        WREADY = 0; stall_left = 2; stalled = 1;
      end else begin
        WREADY = !rand_ready || ($urandom_range(0, 3) != 0);
      end
      BVALID  = b_pend && !b_never;
      ARREADY = ARVALID && (!rand_ready || $urandom_range(0, 1) == 1);
      if (!(p_rv && !p_rr)) begin
        if (r_act) begin
          RVALID = !rand_ready || ($urandom_range(0, 3) != 0);
          RDATA  = mem[(s_addr + rj) % DEPTH];
          if (rj == corrupt_beat) RDATA[0] = ~RDATA[0];
          RLAST  = (rj == s_len) || (rj == early_last);
        end else begin
          RVALID = 0; RLAST = 0;
        end
      end
      p_awv = AWVALID; p_awr = AWREADY; p_awaddr = AWADDR; p_awlen = AWLEN;
      p_wv = WVALID; p_wr = WREADY; p_wdata = WDATA; p_wl = WLAST;
      p_bv = BVALID; p_br = BREADY; p_arv = ARVALID; p_arr = ARREADY;
      p_rv = RVALID; p_rr = RREADY; p_rl = RLAST;
    end
  end

  // Reference: each lane of beat k holds seed + k.
  function automatic logic [DATA_W-1:0] exp_beat(input logic [31:0] s, input int k);
    logic [DATA_W-1:0] v;
    for (int i = 0; i < int'(NW); i++) v[i*32 +: 32] = s + 32'(k);
    return v;
  endfunction

  task automatic clear_obs();
    #1;
    aw_seen = 0; ar_seen = 0; w_beats = 0; r_beats = 0; hold_viol = 0; b_first = -1;
    wcap.delete(); wlast_cap.delete();
    rand_ready = 1; b_never = 0; w_stall_beat = -1; corrupt_beat = -1; early_last = -1;
  endtask

  task automatic run_burst(input logic [ADDR_W-1:0] a, input logic [7:0] l, input logic [31:0] s,
                           output logic p, output logic [7:0] ec, output logic [2:0] st,
                           output int done_cyc);
    bit got;
    int cyc;
    p = 1'bx; ec = 'x; st = 'x; done_cyc = -1; got = 0; cyc = 0;
    @(negedge ACLK);
    start = 1; cfg_addr = a; cfg_len = l; cfg_seed = s;
    @(negedge ACLK);
    start = 0;
    while (!got && cyc < 2000) begin
      if (done) begin
        got = 1; p = pass; ec = err_cnt; st = status; done_cyc = ncyc;
      end else begin
        @(negedge ACLK); cyc++;
      end
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL done_wait got no done want done within 2000 cycles");
    end
  endtask

  task automatic test_reset();
    logic [9:0] ctl;
    ctl = {AWVALID, WVALID, WLAST, BREADY, ARVALID, RREADY, busy, done, pass, 1'b0};
    checks++;
    if (ctl !== 10'd0) begin errors++; $display("FAIL reset_ctl got %b want 0", ctl); end
    checks++;
    if (err_cnt !== 8'd0 || status !== 3'd0) begin
      errors++; $display("FAIL reset_cnt got err=%0d st=%b want 0/000", err_cnt, status);
    end
    checks++;
    if (AWADDR !== '0 || ARADDR !== '0 || AWLEN !== 8'd0 || WDATA !== '0) begin
      errors++; $display("FAIL reset_payload got aw=%h len=%h want 0", AWADDR, AWLEN);
    end
  endtask

  task automatic test_basic();
    logic p; logic [7:0] ec; logic [2:0] st; int dc;
    clear_obs();
    run_burst(64'd0, 8'd3, 32'hA5A5_0000, p, ec, st, dc);
    checks++;
    if (p !== 1'b1 || ec !== 8'd0 || st !== 3'd0) begin
      errors++; $display("FAIL basic_result got p=%b e=%0d s=%b want 1/0/000", p, ec, st);
    end
    checks++;
    if (w_beats != 4 || r_beats != 4) begin
      errors++; $display("FAIL basic_beats got w=%0d r=%0d want 4/4", w_beats, r_beats);
    end
    for (int k = 0; k < 4 && k < wcap.size(); k++) begin
      checks++;
      if (wcap[k] !== exp_beat(32'hA5A5_0000, k) || wlast_cap[k] != (k == 3)) begin
        errors++;
        $display("FAIL basic_wbeat%0d got %h last=%0b want %h last=%0b", k, wcap[k],
                 wlast_cap[k], exp_beat(32'hA5A5_0000, k), k == 3);
      end
    end
    checks++;
    if (b_first < 0) begin errors++; $display("FAIL basic_bready got never want seen"); end
  endtask

  task automatic test_single();
    logic p; logic [7:0] ec; logic [2:0] st; int dc;
    clear_obs();
    run_burst(64'd10, 8'd0, 32'h1234_5678, p, ec, st, dc);
    checks++;
    if (p !== 1'b1 || w_beats != 1 || r_beats != 1) begin
      errors++; $display("FAIL single got p=%b w=%0d r=%0d want 1/1/1", p, w_beats, r_beats);
    end
    checks++;
    if (wlast_cap.size() != 1 || wlast_cap[0] != 1'b1 || wcap[0] !== exp_beat(32'h1234_5678, 0)) begin
      errors++; $display("FAIL single_wlast got n=%0d want one beat with WLAST", wlast_cap.size());
    end
  endtask

  task automatic test_cfg_err();
    logic p; logic [7:0] ec; logic [2:0] st; int dc;
    clear_obs();
    run_burst(64'd60, 8'd7, 32'h0, p, ec, st, dc);
    checks++;
    if (st !== 3'b001 || p !== 1'b0 || aw_seen != 0 || ar_seen != 0) begin
      errors++;
      $display("FAIL cfg_err got s=%b p=%b aw=%0d ar=%0d want 001/0/0/0", st, p, aw_seen, ar_seen);
    end
    clear_obs();
    run_burst(64'd1, 8'd63, 32'h0, p, ec, st, dc);
    checks++;
    if (st !== 3'b001 || aw_seen != 0) begin
      errors++; $display("FAIL cfg_edge_bad got s=%b aw=%0d want 001/0", st, aw_seen);
    end
    clear_obs();
    run_burst(64'd0, 8'd63, 32'hCAFE_0000, p, ec, st, dc);
    checks++;
    if (p !== 1'b1 || st !== 3'b000 || w_beats != 64) begin
      errors++; $display("FAIL cfg_edge_ok got p=%b s=%b w=%0d want 1/000/64", p, st, w_beats);
    end
  endtask

  task automatic test_corrupt();
    logic p; logic [7:0] ec; logic [2:0] st; int dc;
    clear_obs();
    corrupt_beat = 2;
    run_burst(64'd20, 8'd3, 32'h0BAD_0000, p, ec, st, dc);
    checks++;
    if (ec !== 8'd1 || p !== 1'b0 || st !== 3'd0) begin
      errors++; $display("FAIL corrupt got e=%0d p=%b s=%b want 1/0/000", ec, p, st);
    end
  endtask

  task automatic test_stall();
    logic p; logic [7:0] ec; logic [2:0] st; int dc;
    clear_obs();
    rand_ready = 0; w_stall_beat = 1;
    run_burst(64'd5, 8'd3, 32'h5555_0000, p, ec, st, dc);
    checks++;
    if (hold_viol != 0 || p !== 1'b1) begin
      errors++; $display("FAIL stall got viol=%0d p=%b want 0/1", hold_viol, p);
    end
    for (int k = 0; k < 4 && k < wcap.size(); k++) begin
      checks++;
      if (wcap[k] !== exp_beat(32'h5555_0000, k)) begin
        errors++; $display("FAIL stall_wbeat%0d got %h want %h", k, wcap[k], exp_beat(32'h5555_0000, k));
      end
    end
  endtask

  task automatic test_early_last();
    logic p; logic [7:0] ec; logic [2:0] st; int dc;
    clear_obs();
    early_last = 1;
    run_burst(64'd30, 8'd3, 32'h7777_0000, p, ec, st, dc);
    checks++;
    if (st !== 3'b010 || p !== 1'b0 || r_beats != 2) begin
      errors++; $display("FAIL early_last got s=%b p=%b r=%0d want 010/0/2", st, p, r_beats);
    end
  endtask

  task automatic test_timeout();
    logic p; logic [7:0] ec; logic [2:0] st; int dc;
    clear_obs();
    b_never = 1;
    run_burst(64'd40, 8'd2, 32'h0, p, ec, st, dc);
    checks++;
    if (st !== 3'b100 || p !== 1'b0) begin
      errors++; $display("FAIL timeout got s=%b p=%b want 100/0", st, p);
    end
    checks++;
    if (b_first < 0 || dc - b_first < int'(TIMEOUT) || dc - b_first > int'(TIMEOUT) + 10) begin
      errors++; $display("FAIL timeout_len got %0d cycles want about %0d", dc - b_first, TIMEOUT);
    end
    checks++;
    if (BREADY !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL timeout_drop got bready=%b busy=%b want 0/1", BREADY, busy);
    end
  endtask

  task automatic test_reset_mid();
    logic p; logic [7:0] ec; logic [2:0] st; int dc; int n;
    clear_obs();
    rand_ready = 0; w_stall_beat = 3;
    @(negedge ACLK);
    start = 1; cfg_addr = 64'd8; cfg_len = 8'd7; cfg_seed = 32'h9999_0000;
    @(negedge ACLK);
    start = 0;
    n = 0;
    while (!WVALID && n < 50) begin @(negedge ACLK); n++; end
    #2 ARESETn = 0;
    #1;
    checks++;
    if (WVALID !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_mid got wv=%b busy=%b done=%b want 0/0/0", WVALID, busy, done);
    end
    @(negedge ACLK);
    #2 ARESETn = 1;
    clear_obs();
    run_burst(64'd8, 8'd7, 32'h9999_0000, p, ec, st, dc);
    checks++;
    if (p !== 1'b1 || w_beats != 8 || r_beats != 8) begin
      errors++; $display("FAIL reset_after got p=%b w=%0d r=%0d want 1/8/8", p, w_beats, r_beats);
    end
  endtask

  task automatic test_random();
    logic p; logic [7:0] ec; logic [2:0] st; int dc;
    logic [7:0] l; logic [ADDR_W-1:0] a; logic [31:0] s;
    for (int it = 0; it < 8; it++) begin
      clear_obs();
      l = 8'($urandom_range(0, 15));
      a = ADDR_W'($urandom_range(0, DEPTH - 1 - int'(l)));
      s = $urandom;
      if ($urandom_range(0, 1) == 1) w_stall_beat = $urandom_range(0, int'(l));
      run_burst(a, l, s, p, ec, st, dc);
      checks++;
      if (p !== 1'b1 || ec !== 8'd0 || st !== 3'd0 || hold_viol != 0) begin
        errors++; $display("FAIL rand%0d result got p=%b e=%0d s=%b v=%0d want 1/0/000/0", it,
                           p, ec, st, hold_viol);
      end
      checks++;
      if (w_beats != int'(l) + 1 || r_beats != int'(l) + 1) begin
        errors++; $display("FAIL rand%0d beats got w=%0d r=%0d want %0d", it, w_beats, r_beats,
                           int'(l) + 1);
      end
      for (int k = 0; k < wcap.size(); k++) begin
        checks++;
        if (wcap[k] !== exp_beat(s, k) || wlast_cap[k] != (k == int'(l))) begin
          errors++; $display("FAIL rand%0d wbeat%0d got %h want %h", it, k, wcap[k], exp_beat(s, k));
        end
      end
    end
  endtask

  initial begin
    #12;
    test_reset();
    @(negedge ACLK);
    #2 ARESETn = 1;
    test_basic();
    test_single();
    test_cfg_err();
    test_corrupt();
    test_stall();
    test_early_last();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
